// File: rtl/ccff_bitstream_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
package ccff_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_BYTE, SHIFT, DONE} state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
endpackage

// File: rtl/ccff_bitstream_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
interface ccff_bitstream_loader_if;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;

  modport master (output cfg_data, output cfg_valid, input  cfg_ready);
  modport slave  (input  cfg_data, input  cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_bitstream_loader_crc16.sv
// Serial CRC-16-CCITT (MSB-first, no reflection), one bit per enabled clock.
module ccff_crc16_serial
  import ccff_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);
  logic [15:0] crc_q, crc_d;
  logic        fb;

  always_comb begin
    fb    = crc_q[15] ^ din;
    crc_d = crc_q;
    if (clear)   crc_d = CRC16_INIT;
    else if (en) crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) crc_q <= CRC16_INIT;
    else     crc_q <= crc_d;

  assign crc = crc_q;
endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serializes configuration bytes MSB-first into the fabric chain and
// CRCs the previous configuration as it falls out of ccff_tail.
module ccff_bitstream_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 18,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                   prog_clk,
  input  logic                   prog_reset,
  input  logic                   cfg_start,
  ccff_bitstream_loader_if.slave cfg,
  output logic                   ccff_head,
  input  logic                   ccff_tail,
  output logic                   chain_shift_en,
  output logic                   cfg_busy,
  output logic                   cfg_done,
  output logic [15:0]            tail_crc
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN);

  state_t           state_q, state_d;
  logic [7:0]       sr_q, sr_d;
  logic [3:0]       bcnt_q, bcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             head_q, head_d;
  logic             en_q, en_d;
  logic             start_ok;

  assign start_ok = cfg_start && (state_q == IDLE || state_q == DONE);

  // cnt_q counts bits already presented, including the one now on ccff_head,
  // so the chain-length test wins over the end-of-byte test mid-byte.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bcnt_d  = bcnt_q;
    cnt_d   = cnt_q;
    head_d  = head_q;
    en_d    = en_q;
    case (state_q)
      IDLE, DONE: if (cfg_start) begin
        state_d = WAIT_BYTE;
        cnt_d   = '0;
      end
      WAIT_BYTE: if (cfg.cfg_valid) begin
        head_d  = cfg.cfg_data[7];
        sr_d    = {cfg.cfg_data[6:0], 1'b0};
        bcnt_d  = 4'd1;
        cnt_d   = cnt_q + 1'b1;
        en_d    = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: if (cnt_q == LAST) begin
        head_d  = 1'b0;
        en_d    = 1'b0;
        state_d = DONE;
      end else if (bcnt_q == 4'd8) begin
        head_d  = 1'b0;
        en_d    = 1'b0;
        state_d = WAIT_BYTE;
      end else begin
        head_d  = sr_q[7];
        sr_d    = {sr_q[6:0], 1'b0};
        bcnt_d  = bcnt_q + 4'd1;
        cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or posedge prog_reset)
    if (prog_reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bcnt_q  <= '0;
      cnt_q   <= '0;
      head_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bcnt_q  <= bcnt_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      en_q    <= en_d;
    end

  // en_q is high exactly in SHIFT, so ready and shift enable never overlap.
  assign cfg.cfg_ready   = (state_q == WAIT_BYTE);
  assign cfg_busy        = (state_q == WAIT_BYTE) || (state_q == SHIFT);
  assign cfg_done        = (state_q == DONE);
  assign ccff_head       = head_q;
  assign chain_shift_en  = en_q;

  ccff_crc16_serial u_crc (
    .clk   (prog_clk),
    .rst   (prog_reset),
    .clear (start_ok),
    .en    (en_q),
    .din   (ccff_tail),
    .crc   (tail_crc)
  );
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: fabric chain model, table vectors, random loads.
module tb_ccff_bitstream_loader;
  localparam int L  = 18;
  localparam int L8 = 8;

  logic        prog_clk = 1'b0;
  logic        prog_reset;
  logic        start18, head18, tail18, en18, busy18, done18;
  logic        start8, head8, tail8, en8, busy8, done8;
  logic [15:0] crc18, crc8;

  always #5 prog_clk = ~prog_clk;

  ccff_bitstream_loader_if if18 ();
  ccff_bitstream_loader_if if8 ();

  ccff_bitstream_loader #(.CHAIN_LEN(L)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .cfg_start(start18), .cfg(if18),
    .ccff_head(head18), .ccff_tail(tail18), .chain_shift_en(en18),
    .cfg_busy(busy18), .cfg_done(done18), .tail_crc(crc18));

  ccff_bitstream_loader #(.CHAIN_LEN(L8)) dut8 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .cfg_start(start8), .cfg(if8),
    .ccff_head(head8), .ccff_tail(tail8), .chain_shift_en(en8),
    .cfg_busy(busy8), .cfg_done(done8), .tail_crc(crc8));

  // Fabric chains: gated prog_clk, head enters bit 0, tail is the last bit.
  logic [L-1:0]  chain18 = '0;
  logic [L8-1:0] chain8  = '0;
  assign tail18 = chain18[L-1];
  assign tail8  = chain8[L8-1];
  always @(posedge prog_clk) begin
    if (en18) chain18 <= {chain18[L-2:0], head18};
    if (en8)  chain8  <= {chain8[L8-2:0], head8};
  end

  int cyc = 0;
  int overlap = 0;
  bit cap[$];
  bit cap8[$];
  always @(posedge prog_clk) cyc <= cyc + 1;
  always @(negedge prog_clk) begin
    if (en18) cap.push_back(head18);
    if (en8)  cap8.push_back(head8);
    if (en18 && if18.cfg_ready) overlap <= overlap + 1;
  end

  int checks = 0;
  int errors = 0;
  logic [17:0] prev;
  bit          prev_known;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge prog_clk);
    #1;
  endtask

  // CRC-16-CCITT over the n low bits of v, v[n-1] first.
  function automatic logic [15:0] crc_ref(input logic [31:0] v, input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[15] ^ v[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic do_reset(input string nm);
    chk({nm, " shifting before reset"}, 32'(en18), 32'd1);
    prog_reset = 1'b1;
    #1;
    chk({nm, " outputs under reset"},
        32'({en18, busy18, head18, if18.cfg_ready, done18, crc18}), 32'({5'b0, 16'hFFFF}));
    tick;
    prog_reset = 1'b0;
    tick;
    prev_known = 1'b0;
  endtask

  task automatic run_load(input string nm, input logic [23:0] bytes, input int gap,
                          input bit mid, input logic [17:0] exp, input int rst_at);
    int          hs, dn, budget;
    bit          gap_bad;
    logic [17:0] got;
    hs = 0;
    gap_bad = 1'b0;
    cap.delete();
    start18 = 1'b1;
    tick;
    start18 = 1'b0;
    chk({nm, " busy/done after start"}, 32'({busy18, done18}), 32'h2);
    for (int k = 0; k < 3; k++) begin
      budget = 0;
      while (!if18.cfg_ready && budget < 30) begin
        if (rst_at >= 0 && cap.size() == rst_at) begin
          start18 = 1'b0;
          do_reset(nm);
          return;
        end
        tick;
        start18 = 1'b0;
        budget++;
      end
      if (!if18.cfg_ready) begin
        chk({nm, " ready timeout"}, 32'd0, 32'd1);
        return;
      end
      if (k > 0) repeat (gap) begin
        tick;
        if (en18) gap_bad = 1'b1;
      end
      if18.cfg_data  = bytes[23-8*k -: 8];
      if18.cfg_valid = 1'b1;
      if (k == 0) hs = cyc;
      tick;
      if18.cfg_valid = 1'b0;
      if18.cfg_data  = 8'($urandom);
      start18 = mid && (k == 1);
    end
    budget = 0;
    while (!done18 && budget < 40) begin
      tick;
      start18 = 1'b0;
      budget++;
    end
    dn = cyc;
    chk({nm, " done reached"}, 32'(done18), 32'd1);
    // Handshakes plus shifts take 21 cycles; done shows in the one after.
    chk({nm, " done latency"}, 32'(dn - hs), 32'(21 + 2 * gap));
    chk({nm, " shift count"}, 32'(cap.size()), 32'(L));
    got = '0;
    foreach (cap[i]) got = {got[16:0], cap[i]};
    chk({nm, " head stream"}, 32'(got), 32'(exp));
    if (prev_known) chk({nm, " tail crc"}, 32'(crc18), 32'(crc_ref({14'b0, prev}, L)));
    if (gap > 0) chk({nm, " no shift in gap"}, 32'(gap_bad), 32'd0);
    chk({nm, " idle after done"}, 32'({busy18, if18.cfg_ready}), 32'd0);
    prev       = exp;
    prev_known = 1'b1;
  endtask

  typedef struct {
    string       nm;
    logic [23:0] bytes;
    int          gap;
    bit          mid;
    logic [17:0] exp;
  } vec_t;
  vec_t tbl[5];

  initial begin
    logic [31:0] r;
    int          hs8, dn8, budget;
    bit          ready_seen;
    logic [7:0]  got8;

    tbl[0] = '{"a53cc0",   24'hA53CC0, 0, 1'b0, 18'b101001010011110011};
    tbl[1] = '{"readback", 24'h000000, 0, 1'b0, 18'b000000000000000000};
    tbl[2] = '{"gap5",     24'hFF0040, 5, 1'b0, 18'b111111110000000001};
    tbl[3] = '{"midstart", 24'h00FF80, 0, 1'b1, 18'b000000001111111110};
    tbl[4] = '{"gap2",     24'h1234FF, 2, 1'b0, 18'b000100100011010011};

    prog_reset = 1'b1;
    start18 = 1'b0; start8 = 1'b0;
    if18.cfg_valid = 1'b0; if18.cfg_data = '0;
    if8.cfg_valid  = 1'b0; if8.cfg_data  = '0;
    prev = '0;
    prev_known = 1'b1;
    tick; tick;
    chk("reset state", 32'({if18.cfg_ready, head18, en18, busy18, done18, crc18}),
        32'({5'b0, 16'hFFFF}));
    prog_reset = 1'b0;
    tick;

    for (int i = 0; i < 5; i++)
      run_load(tbl[i].nm, tbl[i].bytes, tbl[i].gap, tbl[i].mid, tbl[i].exp, -1);

    run_load("reset mid", 24'hA53CC0, 0, 1'b0, 18'b101001010011110011, 10);
    run_load("after reset", 24'h5AC3FF, 0, 1'b0, 18'b010110101100001111, -1);

    for (int n = 0; n < 8; n++) begin
      r = $urandom;
      run_load("random", r[23:0], int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               r[23:6], -1);
    end
    chk("ready with shift enable", 32'(overlap), 32'd0);

    // Eight-bit chain: one byte fills it exactly.
    cap8.delete();
    hs8 = 0;
    start8 = 1'b1;
    tick;
    start8 = 1'b0;
    budget = 0;
    while (!if8.cfg_ready && budget < 5) begin tick; budget++; end
    chk("len8 ready", 32'(if8.cfg_ready), 32'd1);
    if8.cfg_data  = 8'hFF;
    if8.cfg_valid = 1'b1;
    hs8 = cyc;
    tick;
    budget = 0;
    while (!done8 && budget < 20) begin tick; budget++; end
    dn8 = cyc;
    chk("len8 done", 32'(done8), 32'd1);
    chk("len8 done latency", 32'(dn8 - hs8), 32'd9);
    chk("len8 shift count", 32'(cap8.size()), 32'(L8));
    got8 = '0;
    foreach (cap8[i]) got8 = {got8[6:0], cap8[i]};
    chk("len8 head stream", 32'(got8), 32'hFF);
    chk("len8 tail crc", 32'(crc8), 32'(crc_ref(32'd0, L8)));
    ready_seen = 1'b0;
    repeat (12) begin
      tick;
      if (if8.cfg_ready) ready_seen = 1'b1;
    end
    if8.cfg_valid = 1'b0;
    chk("len8 ready stays low", 32'(ready_seen), 32'd0);
    chk("len8 done held", 32'({done8, busy8}), 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
